// File: rtl/axi3_wr_arbiter_pkg.sv
// Shared types and constants for the AXI3 write arbiter.
package axi3_arb_pkg;

    localparam int ID_W  = 3;
    localparam int LEN_W = 4;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } arb_state_e;

    // Next round-robin pointer: one past the last grant, wrapping at n-1.
    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] idx,
                                                 input int unsigned     n);
        return ((32'(idx) + 32'd1) >= n) ? '0 : idx + ID_W'(1);
    endfunction

endpackage

// File: rtl/axi3_wr_arbiter_rr.sv
// Rotating-priority grant: first asserted request at or after ptr, wrapping.
module axi3_rr_arbiter
    import axi3_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
)
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               gnt_vld,
    output logic [ID_W-1:0]    gnt_idx
);

    localparam logic [31:0] N_U = 32'(NUM_REQ);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [31:0]          sel;

    always_comb begin
        req_dbl = {req, req};
        req_rot = NUM_REQ'(req_dbl >> ptr);
        gnt_vld = 1'b0;
        gnt_idx = '0;
        sel     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!gnt_vld && req_rot[k]) begin
                gnt_vld = 1'b1;
                sel     = 32'(ptr) + k;
                if (sel >= N_U) begin
                    sel = sel - N_U;
                end
                gnt_idx = ID_W'(sel);
            end
        end
    end

endmodule

// File: rtl/axi3_wr_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ write requesters onto one AXI3 write port.
// Optional response watchdog enabled by defining AXI3_ARB_TIMEOUT_EN.
module axi3_wr_arbiter
    import axi3_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
)
(
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic [NUM_REQ-1:0]        s_awvalid,
    output logic [NUM_REQ-1:0]        s_awready,
    input  logic [NUM_REQ*ADDR_W-1:0] s_awaddr,
    input  logic [NUM_REQ*4-1:0]      s_awlen,
    input  logic [NUM_REQ-1:0]        s_wvalid,
    output logic [NUM_REQ-1:0]        s_wready,
    input  logic [NUM_REQ*DATA_W-1:0] s_wdata,
    output logic [NUM_REQ-1:0]        s_bvalid,
    output logic [1:0]                s_bresp,
    output logic                      AWVALID,
    input  logic                      AWREADY,
    output logic [2:0]                AWID,
    output logic [ADDR_W-1:0]         AWADDR,
    output logic [3:0]                AWLEN,
    output logic                      WVALID,
    input  logic                      WREADY,
    output logic [2:0]                WID,
    output logic [DATA_W-1:0]         WDATA,
    output logic                      WLAST,
    input  logic                      BVALID,
    output logic                      BREADY,
    input  logic [2:0]                BID,
    input  logic [1:0]                BRESP
);

    arb_state_e           state_q, state_d;
    logic [ID_W-1:0]      gnt_q, gnt_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [LEN_W-1:0]     beat_q, beat_d;
    logic [NUM_REQ-1:0]   s_awready_q, s_awready_d;
    logic [NUM_REQ-1:0]   s_bvalid_q, s_bvalid_d;
    logic [1:0]           s_bresp_q, s_bresp_d;
    logic                 awvalid_q, awvalid_d;
    logic [ADDR_W-1:0]    awaddr_q, awaddr_d;
    logic [LEN_W-1:0]     awlen_q, awlen_d;
    logic                 bready_q, bready_d;

    logic                 arb_vld;
    logic [ID_W-1:0]      arb_idx;
    logic                 w_hs;

`ifdef AXI3_ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TMR_W-1:0]     timer_q, timer_d;
`endif

    axi3_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req     (s_awvalid),
        .ptr     (rr_ptr_q),
        .gnt_vld (arb_vld),
        .gnt_idx (arb_idx)
    );

    // Write-data channel is a combinational pass-through of the granted requester.
    always_comb begin
        WVALID   = 1'b0;
        WDATA    = '0;
        s_wready = '0;
        if (state_q == ST_DATA) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (gnt_q == ID_W'(i)) begin
                    WVALID      = s_wvalid[i];
                    WDATA       = s_wdata[i*DATA_W +: DATA_W];
                    s_wready[i] = WREADY;
                end
            end
        end
        WLAST = (state_q == ST_DATA) && (beat_q == awlen_q);
        w_hs  = WVALID && WREADY;
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_ptr_d    = rr_ptr_q;
        beat_d      = beat_q;
        s_awready_d = '0;
        s_bvalid_d  = '0;
        s_bresp_d   = OKAY;
        awvalid_d   = awvalid_q;
        awaddr_d    = awaddr_q;
        awlen_d     = awlen_q;
        bready_d    = bready_q;

        unique case (state_q)
            ST_IDLE: begin
                if (arb_vld) begin
                    gnt_d     = arb_idx;
                    awvalid_d = 1'b1;
                    beat_d    = '0;
                    state_d   = ST_ADDR;
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        if (arb_idx == ID_W'(i)) begin
                            s_awready_d[i] = 1'b1;
                            awaddr_d       = s_awaddr[i*ADDR_W +: ADDR_W];
                            awlen_d        = s_awlen[i*LEN_W +: LEN_W];
                        end
                    end
                end
            end
            ST_ADDR: begin
                if (AWREADY) begin
                    awvalid_d = 1'b0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_hs) begin
                    if (beat_q == awlen_q) begin
                        beat_d   = '0;
                        bready_d = 1'b1;
                        state_d  = ST_RESP;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            ST_RESP: begin
                if (BVALID) begin
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        s_bvalid_d[i] = (gnt_q == ID_W'(i));
                    end
                    s_bresp_d = (BID == gnt_q) ? BRESP : SLVERR;
                    bready_d  = 1'b0;
                    rr_ptr_d  = wrap_inc(gnt_q, NUM_REQ);
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef AXI3_ARB_TIMEOUT_EN
        // Timer restarts on every state change; normal progress wins over expiry.
        timer_d = '0;
        if ((state_q != ST_IDLE) && (state_d == state_q)) begin
            if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    s_bvalid_d[i] = (gnt_q == ID_W'(i));
                end
                s_bresp_d = DECERR;
                awvalid_d = 1'b0;
                bready_d  = 1'b0;
                beat_d    = '0;
                rr_ptr_d  = wrap_inc(gnt_q, NUM_REQ);
                state_d   = ST_IDLE;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            rr_ptr_q    <= '0;
            beat_q      <= '0;
            s_awready_q <= '0;
            s_bvalid_q  <= '0;
            s_bresp_q   <= '0;
            awvalid_q   <= 1'b0;
            awaddr_q    <= '0;
            awlen_q     <= '0;
            bready_q    <= 1'b0;
`ifdef AXI3_ARB_TIMEOUT_EN
            timer_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_q      <= beat_d;
            s_awready_q <= s_awready_d;
            s_bvalid_q  <= s_bvalid_d;
            s_bresp_q   <= s_bresp_d;
            awvalid_q   <= awvalid_d;
            awaddr_q    <= awaddr_d;
            awlen_q     <= awlen_d;
            bready_q    <= bready_d;
`ifdef AXI3_ARB_TIMEOUT_EN
            timer_q     <= timer_d;
`endif
        end
    end

    assign s_awready = s_awready_q;
    assign s_bvalid  = s_bvalid_q;
    assign s_bresp   = s_bresp_q;
    assign AWVALID   = awvalid_q;
    assign AWID      = gnt_q;
    assign AWADDR    = awaddr_q;
    assign AWLEN     = awlen_q;
    assign WID       = gnt_q;
    assign BREADY    = bready_q;

endmodule

// File: tb/tb_axi3_wr_arbiter.sv
// Randomized bench for axi3_wr_arbiter against a transaction-level reference model.
module tb_axi3_wr_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef AXI3_ARB_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic            ACLK = 1'b0;
    logic            ARESETn;
    logic [N-1:0]    s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid;
    logic [N*AW-1:0] s_awaddr;
    logic [N*4-1:0]  s_awlen;
    logic [N*DW-1:0] s_wdata;
    logic [1:0]      s_bresp;
    logic            AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
    logic [2:0]      AWID, WID, BID;
    logic [AW-1:0]   AWADDR;
    logic [3:0]      AWLEN;
    logic [DW-1:0]   WDATA;
    logic [1:0]      BRESP;

    axi3_wr_arbiter #(
        .NUM_REQ        (N),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .ACLK      (ACLK),      .ARESETn   (ARESETn),
        .s_awvalid (s_awvalid), .s_awready (s_awready),
        .s_awaddr  (s_awaddr),  .s_awlen   (s_awlen),
        .s_wvalid  (s_wvalid),  .s_wready  (s_wready),
        .s_wdata   (s_wdata),   .s_bvalid  (s_bvalid),
        .s_bresp   (s_bresp),
        .AWVALID   (AWVALID),   .AWREADY   (AWREADY),
        .AWID      (AWID),      .AWADDR    (AWADDR),
        .AWLEN     (AWLEN),
        .WVALID    (WVALID),    .WREADY    (WREADY),
        .WID       (WID),       .WDATA     (WDATA),
        .WLAST     (WLAST),
        .BVALID    (BVALID),    .BREADY    (BREADY),
        .BID       (BID),       .BRESP     (BRESP)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: one transaction in flight, tracked by phase flags.
    bit          idle_m, granted_m, aw_done_m;
    int          ptr_m, g_m, beats_m, stall_m;
    int unsigned addr_cyc;
    logic [AW-1:0] addr_m;
    logic [3:0]  len_m;
    logic [N-1:0] awv_prev, exp_bv;
    logic [1:0]  exp_resp;

    int          n_done, w_beats_obs, wlast_obs, awv_cyc_obs, last_bv_idx;
    logic [1:0]  last_bresp;
    int          grant_log[$];

    int unsigned p_req, p_wd, p_wv, p_aw, p_w, p_b, p_bnoise, p_badid, len_max, aw_stall;
    int          force_bid;
    logic [N-1:0] req_mask;
    bit          fix_addr, rand_resp;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic bit resp_phase();
        return granted_m && aw_done_m && (beats_m == int'(len_m) + 1);
    endfunction

    task automatic observe();
        logic [N-1:0] exp_aw;
        int g;
        exp_aw = '0;
        g = -1;
        if (idle_m && awv_prev != '0) begin
            g = pick(awv_prev, ptr_m);
            exp_aw[g] = 1'b1;
        end
        chk("s_awready", s_awready, exp_aw);
        if (g >= 0) begin
            idle_m = 0; granted_m = 1; g_m = g; aw_done_m = 0;
            beats_m = 0; stall_m = 0; addr_cyc = 0;
            addr_m = s_awaddr[g*AW +: AW];
            len_m  = s_awlen[g*4 +: 4];
            grant_log.push_back(g);
            s_awvalid[g] = 1'b0;
        end
        chk("s_bvalid", s_bvalid, exp_bv);
        for (int i = 0; i < N; i++) if (s_bvalid[i]) last_bv_idx = i;
        if (exp_bv != '0) begin
            chk("s_bresp", s_bresp, exp_resp);
            last_bresp = s_bresp;
            idle_m = 1; granted_m = 0;
            ptr_m = (g_m + 1) % N;
            n_done++;
        end
        exp_bv = '0;
        chk("AWVALID", AWVALID, granted_m && !aw_done_m);
        if (AWVALID) awv_cyc_obs++;
        if (granted_m && !aw_done_m) begin
            chk("AWADDR", AWADDR, addr_m);
            chk("AWLEN", AWLEN, len_m);
            chk("AWID", AWID, 3'(g_m));
        end
        chk("BREADY", BREADY, resp_phase());
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (s_awvalid[i]) begin
                if ($urandom_range(99) < p_wd) s_awvalid[i] = 1'b0;
            end else if (req_mask[i] && $urandom_range(99) < p_req) begin
                s_awvalid[i] = 1'b1;
                s_awaddr[i*AW +: AW] = fix_addr ? 32'h100 : $urandom;
                s_awlen[i*4 +: 4]    = fix_addr ? 4'd3 : 4'($urandom_range(len_max));
            end
            s_wvalid[i] = ($urandom_range(99) < p_wv);
            s_wdata[i*DW +: DW] = $urandom;
        end
        if (granted_m && !aw_done_m && addr_cyc < aw_stall) AWREADY = 1'b0;
        else AWREADY = ($urandom_range(99) < p_aw);
        WREADY = ($urandom_range(99) < p_w);
        BVALID = resp_phase() ? ($urandom_range(99) < p_b) : ($urandom_range(99) < p_bnoise);
        if (force_bid >= 0) BID = 3'(force_bid);
        else BID = ($urandom_range(99) < p_badid) ? 3'($urandom_range(7)) : 3'(g_m);
        BRESP = rand_resp ? 2'($urandom_range(3)) : 2'b00;
        awv_prev = s_awvalid;
    endtask

    task automatic check_comb();
        bit dp, aw_hs, w_hs, b_hs, prog;
        logic [N-1:0] exp_wr;
        dp = granted_m && aw_done_m && (beats_m <= int'(len_m));
        chk("WVALID", WVALID, dp ? s_wvalid[g_m] : 1'b0);
        chk("WLAST", WLAST, dp && (beats_m == int'(len_m)));
        exp_wr = '0;
        if (dp && WREADY) exp_wr[g_m] = 1'b1;
        chk("s_wready", s_wready, exp_wr);
        if (dp && s_wvalid[g_m]) begin
            chk("WDATA", WDATA, s_wdata[g_m*DW +: DW]);
            chk("WID", WID, 3'(g_m));
        end
        if (WVALID && WREADY) begin
            w_beats_obs++;
            if (WLAST) wlast_obs++;
        end
        aw_hs = granted_m && !aw_done_m && AWREADY;
        w_hs  = dp && s_wvalid[g_m] && WREADY;
        b_hs  = resp_phase() && BVALID;
        prog  = aw_hs || (w_hs && beats_m == int'(len_m)) || b_hs;
        if (granted_m && !aw_done_m) addr_cyc++;
        if (b_hs) begin
            exp_bv[g_m] = 1'b1;
            exp_resp = (BID == 3'(g_m)) ? BRESP : 2'b10;
        end
`ifdef AXI3_ARB_TIMEOUT_EN
        if (granted_m && !prog && stall_m == TO - 1) begin
            exp_bv[g_m] = 1'b1;
            exp_resp = 2'b11;
        end
`endif
        if (aw_hs) aw_done_m = 1;
        if (w_hs) beats_m++;
        stall_m = prog ? 0 : stall_m + 1;
    endtask

    task automatic step();
        @(posedge ACLK); #1;
        observe();
        drive();
        #1;
        check_comb();
    endtask

    task automatic do_reset();
        ARESETn = 1'b0;
        s_awvalid = '0; s_wvalid = '0;
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0;
        @(posedge ACLK); #1;
        chk("rst_s_awready", s_awready, 0);
        chk("rst_s_bvalid", s_bvalid, 0);
        chk("rst_s_bresp", s_bresp, 0);
        chk("rst_s_wready", s_wready, 0);
        chk("rst_AWVALID", AWVALID, 0);
        chk("rst_AWID", AWID, 0);
        chk("rst_AWADDR", AWADDR, 0);
        chk("rst_AWLEN", AWLEN, 0);
        chk("rst_WVALID", WVALID, 0);
        chk("rst_WID", WID, 0);
        chk("rst_WDATA", WDATA, 0);
        chk("rst_WLAST", WLAST, 0);
        chk("rst_BREADY", BREADY, 0);
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        idle_m = 1; granted_m = 0; aw_done_m = 0;
        ptr_m = 0; beats_m = 0; stall_m = 0; addr_cyc = 0;
        exp_bv = '0; awv_prev = '0;
        n_done = 0; w_beats_obs = 0; wlast_obs = 0; awv_cyc_obs = 0;
        last_bv_idx = -1; last_bresp = 2'b01;
        grant_log.delete();
    endtask

    task automatic directed_knobs(input logic [N-1:0] mask);
        req_mask = mask; p_req = 100; p_wd = 0; p_wv = 100; p_aw = 100; p_w = 100;
        p_b = 100; p_bnoise = 0; p_badid = 0; len_max = 1; aw_stall = 0;
        force_bid = -1; fix_addr = 0; rand_resp = 0;
    endtask

    task automatic run_until_done(input string tag, input int target, input int budget);
        int c;
        c = 0;
        while (n_done < target && c < budget) begin
            step();
            c++;
        end
        chk(tag, n_done >= target, 1);
    endtask

    initial begin
        s_awaddr = '0; s_awlen = '0; s_wdata = '0; BID = '0; BRESP = '0;
        g_m = 0;
        directed_knobs('0);
        do_reset();

        // Single burst of four beats from requester 0.
        directed_knobs(4'b0001);
        fix_addr = 1;
        run_until_done("t031_done", 1, 200);
        chk("t031_beats", w_beats_obs, 4);
        chk("t031_wlast", wlast_obs, 1);
        chk("t031_resp", last_bresp, 2'b00);
        chk("t031_gnt", grant_log.size() > 0 ? grant_log[0] : -1, 0);

        // All requesters held: strict rotation.
        do_reset();
        directed_knobs(4'b1111);
        run_until_done("t032_done", 5, 400);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t032_gnt%0d", k), grant_log.size() > k ? grant_log[k] : -1, k % N);
        end

        // Address channel back-pressure.
        do_reset();
        directed_knobs(4'b0010);
        aw_stall = 5;
        run_until_done("t033_done", 1, 200);
        chk("t033_awcyc", awv_cyc_obs, 6);

        // Wrong BID on the response.
        do_reset();
        directed_knobs(4'b0100);
        force_bid = 5;
        rand_resp = 1;
        run_until_done("t034_done", 1, 200);
        chk("t034_idx", last_bv_idx, 2);
        chk("t034_resp", last_bresp, 2'b10);

        // Reset during the third data beat.
        do_reset();
        directed_knobs(4'b0001);
        fix_addr = 1;
        p_wv = 60;
        begin
            int c;
            c = 0;
            while (!(granted_m && aw_done_m && beats_m == 2) && c < 200) begin
                step();
                c++;
            end
            chk("t036_reach_beat2", granted_m && aw_done_m && beats_m == 2, 1);
        end
        do_reset();
        directed_knobs(4'b1111);
        begin
            int c;
            c = 0;
            while (grant_log.size() == 0 && c < 50) begin
                step();
                c++;
            end
            chk("t036_ptr0", grant_log.size() > 0 ? grant_log[0] : -1, 0);
        end

`ifdef AXI3_ARB_TIMEOUT_EN
        // Silent slave: watchdog completes with DECERR.
        do_reset();
        directed_knobs(4'b0010);
        p_b = 0;
        run_until_done("t035_done", 1, 200);
        chk("t035_resp", last_bresp, 2'b11);
        chk("t035_idx", last_bv_idx, 1);
`endif

        // Randomized traffic with periodically reshuffled knobs.
        do_reset();
        for (int blk = 0; blk < 8; blk++) begin
            req_mask  = 4'($urandom_range(1, 15));
            p_req     = $urandom_range(20, 100);
            p_wd      = $urandom_range(0, 10);
            p_wv      = $urandom_range(30, 100);
            p_aw      = $urandom_range(30, 100);
            p_w       = $urandom_range(30, 100);
            p_b       = $urandom_range(30, 100);
            p_bnoise  = $urandom_range(0, 20);
            p_badid   = $urandom_range(0, 30);
            len_max   = $urandom_range(0, 15);
            aw_stall  = 0;
            force_bid = -1;
            fix_addr  = 0;
            rand_resp = 1;
            for (int c = 0; c < 500; c++) step();
        end
        chk("rand_progress", n_done > 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi3_wr_arbiter.md
AXI3_WR_ARBITER -- requirements
Module: axi3_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of write requesters (2..8).
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, response watchdog limit.
REQ-005 SHALL have port ACLK  in  1  clock; reset ARESETn, synchronous, active-low; clock ACLK.
REQ-006 SHALL have port ARESETn  in  1  synchronous active-low reset.
REQ-007 SHALL have port s_awvalid  in  NUM_REQ  per-requester write request.
REQ-008 SHALL have port s_awready  out  NUM_REQ  one-cycle request-accepted pulse.
REQ-009 SHALL have port s_awaddr  in  NUM_REQ*ADDR_W  packed request addresses.
REQ-010 SHALL have port s_awlen  in  NUM_REQ*4  packed burst lengths minus one.
REQ-011 SHALL have port s_wvalid  in  NUM_REQ  per-requester beat valid.
REQ-012 SHALL have port s_wready  out  NUM_REQ  per-requester beat accepted.
REQ-013 SHALL have port s_wdata  in  NUM_REQ*DATA_W  packed beat data.
REQ-014 SHALL have port s_bvalid  out  NUM_REQ  one-cycle completion pulse.
REQ-015 SHALL have port s_bresp  out  2  completion response, qualified by s_bvalid.
REQ-016 SHALL have ports AWVALID out 1, AWREADY in 1, AWID out 3, AWADDR out ADDR_W, AWLEN out 4: shared AXI3 write-address channel.
REQ-017 SHALL have ports WVALID out 1, WREADY in 1, WID out 3, WDATA out DATA_W, WLAST out 1: shared write-data channel.
REQ-018 SHALL have ports BVALID in 1, BREADY out 1, BID in 3, BRESP in 2: shared write-response channel.

Function
REQ-019 SHALL run FSM IDLE->ADDR->DATA->RESP->IDLE, one write outstanding at a time; master-side valids are 0 in IDLE.
REQ-020 IDLE: SHALL grant the first asserted s_awvalid at or after rr_ptr (wrapping at NUM_REQ-1), pulse s_awready[g] one cycle, register addr/len, set AWID=WID=g, enter ADDR next cycle.
REQ-021 ADDR: SHALL hold AWVALID=1 with stable fields until AWREADY sampled 1, then AWVALID=0 and enter DATA.
REQ-022 DATA: SHALL pass WVALID=s_wvalid[g], s_wready[g]=WREADY, WDATA=slice g combinationally; non-granted s_wready=0.
REQ-023 DATA: SHALL count accepted beats from 0; WLAST=1 when count==AWLEN; on last handshake enter RESP with BREADY=1.
REQ-024 RESP: on BVALID SHALL pulse s_bvalid[g] with s_bresp=BRESP, or 2'b10 if BID!=g; BREADY=0; rr_ptr=g+1 mod NUM_REQ; enter IDLE.
REQ-025 Requests arriving during a transaction SHALL wait; s_awvalid deassertion before grant withdraws the request.
REQ-026 AWLEN=0 SHALL yield a single beat with WLAST=1.

Reset
REQ-027 While ARESETn=0 SHALL set state IDLE, rr_ptr=0, beat count=0, all outputs 0; reset mid-transaction abandons it without s_bvalid.

Configuration
REQ-028 With AXI3_ARB_TIMEOUT_EN defined SHALL count cycles in ADDR/DATA/RESP, reset per state change; at TIMEOUT_CYCLES pulse s_bvalid[g] with s_bresp=2'b11, drop all master valids/BREADY, advance rr_ptr, go IDLE. Without it SHALL wait indefinitely and omit the counter.

Structure
REQ-029 Package axi3_arb_pkg SHALL hold the FSM state enum and response constants OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11.
REQ-030 Sub-module axi3_rr_arbiter SHALL implement the rotating-priority grant from request vector and rr_ptr.

Verification
REQ-031 s_awvalid=4'b0001, addr 0x100, len 3, AWREADY=1 -> AWADDR=0x100, 4 beats, WLAST on 4th, s_bvalid[0] with OKAY.
REQ-032 s_awvalid=4'b1111 held -> grants 0,1,2,3,0 in order, AWID matches grant.
REQ-033 AWREADY low 5 cycles -> AWVALID and AWADDR stable 5 cycles, no W beats.
REQ-034 BID=5 for grant 2 -> s_bvalid[2] with s_bresp=2'b10.
REQ-035 AXI3_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, BVALID never -> s_bvalid[g] with 2'b11, FSM in IDLE.
REQ-036 ARESETn=0 in DATA beat 2 -> next cycle all outputs 0, state IDLE, rr_ptr=0.
